// File: rtl/entropy_word_cache_if.sv
// Handshake/bit-stream bundle between the RNG consumer side and entropy_word_cache.
interface entropy_word_cache_if #(
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 4
);
  logic                         i_enb;
  logic                         i_mode;
  logic                         i_ranBit;
  logic                         i_bitValid;
  logic                         i_flush;
  logic                         i_ready;
  logic [WORD_BITS-1:0]         o_data;
  logic                         o_valid;
  logic [$clog2(DEPTH+1)-1:0]   o_level;
  logic                         o_overflow;

  modport master (
    output i_enb, i_mode, i_ranBit, i_bitValid, i_flush, i_ready,
    input  o_data, o_valid, o_level, o_overflow
  );

  modport slave (
    input  i_enb, i_mode, i_ranBit, i_bitValid, i_flush, i_ready,
    output o_data, o_valid, o_level, o_overflow
  );
endinterface

// File: rtl/entropy_word_cache.sv
// Assembles random bits (raw or von Neumann debiased) into words and queues them
// in a zeroising first-word-fall-through FIFO.
module entropy_word_cache #(
  parameter int WORD_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 i_clock,
  input  logic                 i_rst,
  entropy_word_cache_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int CW = $clog2(WORD_BITS+1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BITS);

  logic [WORD_BITS-1:0] asm_q, asm_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 vn_have_q, vn_have_d;
  logic                 vn_bit_q, vn_bit_d;
  logic [WORD_BITS-1:0] mem_q [DEPTH];
  logic [WORD_BITS-1:0] mem_d [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;

  logic offered, cand_vld, cand_bit, asm_full, push, pop;

  always_comb begin
    asm_d     = asm_q;
    cnt_d     = cnt_q;
    vn_have_d = vn_have_q;
    vn_bit_d  = vn_bit_q;
    mem_d     = mem_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    level_d   = level_q;
    ovf_d     = ovf_q;

    offered  = bus.i_enb && bus.i_bitValid;
    // VN emits the first bit of a differing pair; raw passes every offered bit
    cand_vld = bus.i_mode ? (offered && vn_have_q && (vn_bit_q != bus.i_ranBit)) : offered;
    cand_bit = bus.i_mode ? vn_bit_q : bus.i_ranBit;
    asm_full = (cnt_q == CNT_FULL);
    pop      = (level_q != '0) && bus.i_ready;
    push     = asm_full && ((level_q != LVL_FULL) || pop);

    if (!bus.i_mode) begin
      vn_have_d = 1'b0;
    end else if (offered) begin
      vn_have_d = !vn_have_q;
      if (!vn_have_q) vn_bit_d = bus.i_ranBit;
    end

    if (push) begin
      asm_d = cand_vld ? {{(WORD_BITS-1){1'b0}}, cand_bit} : '0;
      cnt_d = cand_vld ? CW'(1) : '0;
    end else if (cand_vld && !asm_full) begin
      asm_d = {asm_q[WORD_BITS-2:0], cand_bit};
      cnt_d = cnt_q + CW'(1);
    end else if (cand_vld) begin
      ovf_d = 1'b1;
    end

    // Pop clears first so a same-slot push at full wins
    if (pop) begin
      mem_d[rd_q] = '0;
      rd_d        = rd_q + AW'(1);
    end
    if (push) begin
      mem_d[wr_q] = asm_q;
      wr_d        = wr_q + AW'(1);
    end
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);

    if (bus.i_flush) begin
      asm_d     = '0;
      cnt_d     = '0;
      vn_have_d = 1'b0;
      vn_bit_d  = 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_d      = '0;
      rd_d      = '0;
      level_d   = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge i_clock or posedge i_rst) begin
    if (i_rst) begin
      asm_q     <= '0;
      cnt_q     <= '0;
      vn_have_q <= 1'b0;
      vn_bit_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      asm_q     <= asm_d;
      cnt_q     <= cnt_d;
      vn_have_q <= vn_have_d;
      vn_bit_q  <= vn_bit_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_data     = (level_q != '0) ? mem_q[rd_q] : '0;
  assign bus.o_valid    = (level_q != '0);
  assign bus.o_level    = level_q;
  assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_entropy_word_cache.sv
// Directed + randomized bench for entropy_word_cache (8-bit words, 4 deep) against a queue model.
module tb_entropy_word_cache;
  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  entropy_word_cache_if #(.WORD_BITS(W), .DEPTH(D)) bus ();
  entropy_word_cache #(.WORD_BITS(W), .DEPTH(D)) dut (.i_clock(clk), .i_rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Reference model: queue of words, bits gathered so far, pending VN first bit
  logic [W-1:0] mq[$];
  int           acc, acc_n, vn_pend;
  bit           movf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    acc = 0; acc_n = 0; vn_pend = -1; movf = 1'b0;
  endtask

  task automatic model_edge(input bit enb, mode, rb, bv, rdy, fl);
    bit pop, push, have_c, cb;
    if (fl) begin model_clear(); return; end
    pop    = (mq.size() > 0) && rdy;
    push   = (acc_n == W) && ((mq.size() < D) || pop);
    have_c = 1'b0; cb = 1'b0;
    if (!mode) begin
      vn_pend = -1;
      if (enb && bv) begin have_c = 1'b1; cb = rb; end
    end else if (enb && bv) begin
      if (vn_pend < 0) vn_pend = int'(rb);
      else begin
        if (vn_pend != int'(rb)) begin have_c = 1'b1; cb = vn_pend[0]; end
        vn_pend = -1;
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin mq.push_back(W'(acc)); acc = 0; acc_n = 0; end
    if (have_c) begin
      if (acc_n < W) begin acc = ((acc << 1) | int'(cb)) & ((1 << W) - 1); acc_n++; end
      else movf = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 32'(bus.o_valid), 32'(mq.size() > 0));
    chk({tag, ".data"},  32'(bus.o_data),  (mq.size() > 0) ? 32'(mq[0]) : 32'h0);
    chk({tag, ".level"}, 32'(bus.o_level), 32'(mq.size()));
    chk({tag, ".ovf"},   32'(bus.o_overflow), 32'(movf));
  endtask

  // One clock: drive at negedge, model follows at posedge, compare at next negedge
  task automatic step(input string tag, input bit enb, mode, rb, bv, rdy, fl);
    bus.i_enb = enb; bus.i_mode = mode; bus.i_ranBit = rb;
    bus.i_bitValid = bv; bus.i_ready = rdy; bus.i_flush = fl;
    @(posedge clk);
    model_edge(enb, mode, rb, bv, rdy, fl);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic raw_bit(input string tag, input bit b, input bit rdy);
    step(tag, 1'b1, 1'b0, b, 1'b1, rdy, 1'b0);
  endtask

  task automatic vn_pair(input string tag, input bit a, input bit b);
    step(tag, 1'b1, 1'b1, a, 1'b1, 1'b0, 1'b0);
    step(tag, 1'b1, 1'b1, b, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input string tag, input bit rdy);
    step(tag, 1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    logic [7:0] pat;
    logic [9:0] vnp;
    model_clear();
    bus.i_enb = 0; bus.i_mode = 0; bus.i_ranBit = 0;
    bus.i_bitValid = 0; bus.i_flush = 0; bus.i_ready = 0;
    rst = 1'b1;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: raw word 1,0,1,1,0,0,1,0 -> B2
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) raw_bit("raw", pat[i], 1'b0);
    idle("raw_hold", 1'b0);
    chk("raw_word", 32'(bus.o_data), 32'hB2);
    chk("raw_level", 32'(bus.o_level), 32'd1);
    idle("raw_pop", 1'b1);
    chk("raw_popped", {31'b0, bus.o_valid} | 32'(bus.o_data), 32'h0);

    // 2: VN pairs 01,10,00,11,10 then 01,10,01,10,10 -> 0110_1011
    vnp = 10'b01_10_00_11_10;
    for (int i = 4; i >= 0; i--) vn_pair("vn", vnp[2*i+1], vnp[2*i]);
    chk("vn_partial", 32'(dut.cnt_q), 32'd3);
    vnp = 10'b01_10_01_10_10;
    for (int i = 4; i >= 0; i--) vn_pair("vn", vnp[2*i+1], vnp[2*i]);
    idle("vn_hold", 1'b0);
    chk("vn_word", 32'(bus.o_data), 32'h6B);
    idle("vn_pop", 1'b1);

    // 3: fill the FIFO, hold a 5th word, overflow on extra bits, then drain
    for (int i = 0; i < 43; i++) raw_bit("full", 1'($urandom), 1'b0);
    chk("full_level", 32'(bus.o_level), 32'd4);
    chk("full_ovf", 32'(bus.o_overflow), 32'd1);
    for (int i = 0; i < 7; i++) idle("drain", 1'b1);
    chk("drain_empty", 32'(bus.o_valid), 32'd0);

    // 4: continuous operation starting from a full FIFO with asm full
    step("flush4", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) raw_bit("fill4", 1'($urandom), 1'b0);
    for (int i = 0; i < 60; i++) raw_bit("cont", 1'($urandom), 1'b1);
    chk("cont_ovf", 32'(bus.o_overflow), 32'd0);

    // 5: flush mid-operation, then async reset mid-cycle
    step("flush5a", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 29; i++) raw_bit("q3", 1'($urandom), 1'b0);
    chk("q3_level", 32'(bus.o_level), 32'd3);
    step("flush5", 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_level", 32'(bus.o_level), 32'd0);
    for (int i = 0; i < 29; i++) raw_bit("q3b", 1'($urandom), 1'b0);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check_outputs("async_rst");
    chk("async_cnt", 32'(dut.cnt_q), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 6: zeroise after popping everything; mode toggle mid-pair
    for (int i = 0; i < 16; i++) raw_bit("z", 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) idle("zpop", 1'b1);
    for (int i = 0; i < D; i++) chk($sformatf("zero_slot%0d", i), 32'(dut.mem_q[i]), 32'h0);
    step("vn_first", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("vn_have_set", 32'(dut.vn_have_q), 32'd1);
    step("vn_tog", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("vn_have_clr", 32'(dut.vn_have_q), 32'd0);
    step("vn_new", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("vn_no_stale", 32'(dut.cnt_q), 32'd0);

    // Randomized mix of every control
    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom),
           1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 99) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
